rx_frame_ctrl: RTL and testbench

//  Receive-side sequencer that feeds rx_data_buff.
//  - Watches the serial line and times each bit with an internal bit counter.
//  - Shifts in DATA_BITS payload bits, LSB first, then checks the stop bit.
//  - On a good frame, presents the assembled byte on packet_data and pulses

---
 rtl/rx_frame_ctrl_if.sv | 26 ++
 rtl/rx_frame_ctrl.sv | 108 ++++++++++
 tb/tb_rx_frame_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_ctrl_if.sv
// Serial receive bundle between the line, rx_frame_ctrl and rx_data_buff.
interface rx_frame_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic                 serial_in;
    logic [DATA_BITS-1:0] packet_data;
    logic                 load_buffer;
    logic                 framing_error;
    logic                 rx_busy;

    modport master (
        output serial_in,
        input  packet_data,
        input  load_buffer,
        input  framing_error,
        input  rx_busy
    );

    modport slave (
        input  serial_in,
        output packet_data,
        output load_buffer,
        output framing_error,
        output rx_busy
    );
endinterface

// File: rtl/rx_frame_ctrl.sv
// Receive sequencer: start detect, mid-bit sampling, LSB-first shift,
// stop check and one-cycle load strobe into rx_data_buff.
module rx_frame_ctrl #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input logic             clk,
    input logic             n_rst,
    rx_frame_ctrl_if.slave  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int SW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [SW-1:0] LAST_BIT = SW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        RECV,
        STOP_CHK,
        LOAD
    } state_t;

    state_t               state, next;
    logic                 sync1, s_in, s_prev;
    logic                 start_edge;
    logic [CW-1:0]        cnt;
    logic [SW-1:0]        nsamp;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr;
    logic                 cnt_clr, shift, ferr_set, ferr_clr;

    assign start_edge = s_prev & ~s_in;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next     = state;
        cnt_clr  = 1'b0;
        shift    = 1'b0;
        ferr_set = 1'b0;
        ferr_clr = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_edge) begin
                    next     = START_CHK;
                    ferr_clr = 1'b1;
                end
            end
            START_CHK: begin
                // A high mid-start sample means the low was only a glitch
                if (cnt == CNT_HALF) next = s_in ? IDLE : RECV;
            end
            RECV: begin
                if (cnt == CNT_MAX) begin
                    shift   = 1'b1;
                    cnt_clr = 1'b1;
                    if (nsamp == LAST_BIT) next = STOP_CHK;
                end
            end
            STOP_CHK: begin
                if (cnt == CNT_MAX) begin
                    if (s_in) begin
                        next = LOAD;
                    end else begin
                        next     = IDLE;
                        ferr_set = 1'b1;
                    end
                end
            end
            LOAD:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1  <= 1'b1;
            s_in   <= 1'b1;
            s_prev <= 1'b1;
            cnt    <= '0;
            nsamp  <= '0;
            shreg  <= '1;
            ferr   <= 1'b0;
        end else begin
            sync1  <= bus.serial_in;
            s_in   <= sync1;
            s_prev <= s_in;
            // Restart timing on any state change; saturate while parked
            if (next != state || cnt_clr) cnt <= '0;
            else if (cnt != CNT_MAX)      cnt <= cnt + 1'b1;
            if (state != RECV) nsamp <= '0;
            else if (shift)    nsamp <= nsamp + 1'b1;
            if (shift) shreg <= {s_in, shreg[DATA_BITS-1:1]};
            if (ferr_set)      ferr <= 1'b1;
            else if (ferr_clr) ferr <= 1'b0;
        end
    end

    assign bus.packet_data   = shreg;
    assign bus.load_buffer   = (state == LOAD);
    assign bus.framing_error = ferr;
    assign bus.rx_busy       = (state != IDLE);
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Self-checking bench for rx_frame_ctrl: directed scenarios plus random
// frames checked against a frame-level timing/data model.
module tb_rx_frame_ctrl;
    localparam int C   = 10;
    // Line fall -> start_edge is 2 sync cycles; start_edge -> load is C/2+9C+1
    localparam int LAT = 2 + C / 2 + 9 * C + 1;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } ev_t;

    logic clk   = 1'b0;
    logic n_rst = 1'b1;
    int   cyc     = 0;
    int   vectors = 0;
    int   errs    = 0;
    ev_t  seen_q[$];

    rx_frame_ctrl_if #(.DATA_BITS(8)) bus ();

    rx_frame_ctrl #(
        .CLKS_PER_BIT(C),
        .DATA_BITS   (8)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (bus.load_buffer === 1'b1) seen_q.push_back('{cyc, bus.packet_data});

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.serial_in = 1'b1;
        end
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop,
                               output int t0);
        @(negedge clk);
        bus.serial_in = 1'b0;
        t0 = cyc;
        repeat (C - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.serial_in = d[i];
            repeat (C - 1) @(negedge clk);
        end
        @(negedge clk);
        bus.serial_in = stop;
        repeat (C - 1) @(negedge clk);
    endtask

    task automatic test_reset;
        bit bad;
        bus.serial_in = 1'b1;
        repeat (3) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        vectors += 4;
        if (bus.packet_data !== 8'hFF) begin
            errs++; $display("FAIL rst_data: got %h want ff", bus.packet_data);
        end
        if (bus.load_buffer !== 1'b0) begin
            errs++; $display("FAIL rst_load: got %b want 0", bus.load_buffer);
        end
        if (bus.framing_error !== 1'b0) begin
            errs++; $display("FAIL rst_ferr: got %b want 0", bus.framing_error);
        end
        if (bus.rx_busy !== 1'b0) begin
            errs++; $display("FAIL rst_busy: got %b want 0", bus.rx_busy);
        end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (bus.rx_busy !== 1'b0) bad = 1'b1;
        end
        vectors += 2;
        if (bad) begin
            errs++; $display("FAIL idle_busy: got 1 want 0");
        end
        if (seen_q.size() != 0) begin
            errs++; $display("FAIL idle_load: got %0d pulses want 0", seen_q.size());
        end
    endtask

    task automatic test_good_frame;
        int t0;
        idle(10);
        seen_q.delete();
        drive_frame(8'hA5, 1'b1, t0);
        idle(5);
        vectors += 4;
        if (seen_q.size() != 1) begin
            errs++; $display("FAIL good_count: got %0d want 1", seen_q.size());
        end
        if (seen_q.size() > 0 && seen_q[0].cyc != t0 + LAT) begin
            errs++; $display("FAIL good_time: got %0d want %0d", seen_q[0].cyc - t0, LAT);
        end
        if (seen_q.size() > 0 && seen_q[0].d !== 8'hA5) begin
            errs++; $display("FAIL good_data: got %h want a5", seen_q[0].d);
        end
        if (bus.framing_error !== 1'b0) begin
            errs++; $display("FAIL good_ferr: got %b want 0", bus.framing_error);
        end
    endtask

    task automatic test_framing_error;
        int t0;
        idle(10);
        seen_q.delete();
        drive_frame(8'h3C, 1'b0, t0);
        idle(20);
        vectors += 3;
        if (seen_q.size() != 0) begin
            errs++; $display("FAIL fe_load: got %0d pulses want 0", seen_q.size());
        end
        if (bus.framing_error !== 1'b1) begin
            errs++; $display("FAIL fe_set: got %b want 1", bus.framing_error);
        end
        if (bus.packet_data !== 8'h3C) begin
            errs++; $display("FAIL fe_data: got %h want 3c", bus.packet_data);
        end
        idle(30);
        vectors++;
        if (bus.framing_error !== 1'b1) begin
            errs++; $display("FAIL fe_sticky: got %b want 1", bus.framing_error);
        end
        fork
            drive_frame(8'h01, 1'b1, t0);
            begin
                @(negedge clk);
                repeat (2) @(negedge clk);
                vectors++;
                if (bus.framing_error !== 1'b1) begin
                    errs++; $display("FAIL fe_pre_edge: got %b want 1", bus.framing_error);
                end
                @(negedge clk);
                vectors += 2;
                if (bus.framing_error !== 1'b0) begin
                    errs++; $display("FAIL fe_clear: got %b want 0", bus.framing_error);
                end
                if (bus.rx_busy !== 1'b1) begin
                    errs++; $display("FAIL fe_busy: got %b want 1", bus.rx_busy);
                end
            end
        join
        idle(5);
        vectors += 2;
        if (seen_q.size() != 1 || seen_q[0].cyc != t0 + LAT) begin
            errs++; $display("FAIL fe_next_pulse: got %0d pulses want 1 at +%0d", seen_q.size(), LAT);
        end
        if (bus.packet_data !== 8'h01) begin
            errs++; $display("FAIL fe_next_data: got %h want 01", bus.packet_data);
        end
    endtask

    task automatic test_glitch;
        int t0;
        idle(10);
        seen_q.delete();
        @(negedge clk);
        bus.serial_in = 1'b0;
        t0 = cyc;
        repeat (2) @(negedge clk);
        @(negedge clk);
        bus.serial_in = 1'b1;
        vectors++;
        if (bus.rx_busy !== 1'b1) begin
            errs++; $display("FAIL gl_start_chk: got %b want 1", bus.rx_busy);
        end
        idle(6);
        vectors++;
        if (bus.rx_busy !== 1'b0) begin
            errs++; $display("FAIL gl_back_idle: got %b want 0 at +%0d", bus.rx_busy, cyc - t0);
        end
        idle(100);
        vectors += 2;
        if (seen_q.size() != 0) begin
            errs++; $display("FAIL gl_load: got %0d pulses want 0", seen_q.size());
        end
        if (bus.framing_error !== 1'b0) begin
            errs++; $display("FAIL gl_ferr: got %b want 0", bus.framing_error);
        end
    endtask

    task automatic test_back_to_back;
        int t0, t1;
        idle(10);
        seen_q.delete();
        drive_frame(8'h00, 1'b1, t0);
        drive_frame(8'hFF, 1'b1, t1);
        idle(5);
        vectors++;
        if (seen_q.size() != 2) begin
            errs++; $display("FAIL b2b_count: got %0d want 2", seen_q.size());
        end else begin
            vectors += 4;
            if (seen_q[0].cyc != t0 + LAT) begin
                errs++; $display("FAIL b2b_time0: got %0d want %0d", seen_q[0].cyc - t0, LAT);
            end
            if (seen_q[1].cyc - seen_q[0].cyc != 10 * C) begin
                errs++; $display("FAIL b2b_gap: got %0d want %0d", seen_q[1].cyc - seen_q[0].cyc, 10 * C);
            end
            if (seen_q[0].d !== 8'h00) begin
                errs++; $display("FAIL b2b_data0: got %h want 00", seen_q[0].d);
            end
            if (seen_q[1].d !== 8'hFF) begin
                errs++; $display("FAIL b2b_data1: got %h want ff", seen_q[1].d);
            end
        end
    endtask

    task automatic test_reset_midframe;
        int t0;
        idle(10);
        seen_q.delete();
        fork
            drive_frame(8'h55, 1'b1, t0);
            begin
                @(negedge clk);
                repeat (55) @(negedge clk);
                vectors++;
                if (bus.rx_busy !== 1'b1) begin
                    errs++; $display("FAIL mr_busy_pre: got %b want 1", bus.rx_busy);
                end
                #2 n_rst = 1'b0;
                #1;
                vectors += 2;
                if (bus.packet_data !== 8'hFF) begin
                    errs++; $display("FAIL mr_data: got %h want ff", bus.packet_data);
                end
                if (bus.rx_busy !== 1'b0) begin
                    errs++; $display("FAIL mr_busy: got %b want 0", bus.rx_busy);
                end
            end
        join
        idle(3);
        n_rst = 1'b1;
        idle(20);
        vectors += 2;
        if (seen_q.size() != 0) begin
            errs++; $display("FAIL mr_load: got %0d pulses want 0", seen_q.size());
        end
        if (bus.packet_data !== 8'hFF) begin
            errs++; $display("FAIL mr_data_hold: got %h want ff", bus.packet_data);
        end
        drive_frame(8'h55, 1'b1, t0);
        idle(5);
        vectors += 2;
        if (seen_q.size() != 1 || seen_q[0].cyc != t0 + LAT) begin
            errs++; $display("FAIL mr_next_pulse: got %0d pulses want 1 at +%0d", seen_q.size(), LAT);
        end
        if (bus.packet_data !== 8'h55) begin
            errs++; $display("FAIL mr_next_data: got %h want 55", bus.packet_data);
        end
    endtask

    task automatic test_random;
        ev_t        exp_q[$];
        int         t0, gap;
        logic [7:0] d;
        logic       stop;
        idle(10);
        seen_q.delete();
        repeat (24) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            drive_frame(d, stop, t0);
            if (stop) exp_q.push_back('{t0 + LAT, d});
            vectors += 2;
            if (bus.framing_error !== !stop) begin
                errs++; $display("FAIL rnd_ferr: got %b want %b data %h", bus.framing_error, !stop, d);
            end
            if (bus.packet_data !== d) begin
                errs++; $display("FAIL rnd_data: got %h want %h", bus.packet_data, d);
            end
            // A bad stop leaves the line low, so a high gap is needed
            if (stop) gap = $urandom_range(0, 1) * $urandom_range(1, 12);
            else      gap = C + $urandom_range(0, 12);
            idle(gap);
        end
        idle(20);
        vectors++;
        if (seen_q.size() != exp_q.size()) begin
            errs++; $display("FAIL rnd_count: got %0d want %0d", seen_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
            vectors++;
            if (seen_q[i].cyc != exp_q[i].cyc || seen_q[i].d !== exp_q[i].d) begin
                errs++;
                $display("FAIL rnd_pulse%0d: got %h@%0d want %h@%0d", i,
                         seen_q[i].d, seen_q[i].cyc, exp_q[i].d, exp_q[i].cyc);
            end
        end
    endtask

    initial begin
        bus.serial_in = 1'b1;
        test_reset();
        test_good_frame();
        test_framing_error();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
